call_panel: RTL and testbench

Floor call-button front end driving the elevator controller's `floor_req` bitmask input. It synchronises raw buttons and optionally debounces them, and converts each new press into a one-cycle request pulse. It holds a per-floor lamp until the controller serves that floor, and re-issues lit calls if the controller stays idle with calls outstanding. It sits between the board pushbuttons and the controller, and consumes the controller's `floor_pos`, `door_open`, `moving_up` and `moving_dn` outputs.

---
 rtl/call_panel.sv | 121 ++++++++++++
 tb/tb_call_panel.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/call_panel.sv
// Floor call-button front end: synchronise, optionally debounce, pulse new presses,
// hold call lamps until served, and re-issue outstanding calls to an idle controller.
// Optional feature macro: CALL_PANEL_DEBOUNCE_EN (per-button debounce counters).
module call_panel #(
    parameter int unsigned FLOORS          = 5,
    parameter int unsigned POS_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned DB_W            = 4,
    parameter int unsigned REISSUE_CYCLES  = 64,
    parameter int unsigned RI_W            = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] btn,
    input  logic [POS_W-1:0]  floor_pos,
    input  logic              door_open,
    input  logic              moving_up,
    input  logic              moving_dn,
    output logic [FLOORS-1:0] floor_req,
    output logic [FLOORS-1:0] lamp,
    output logic              reissue
);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** DB_W) - 1) begin : g_bad_debounce
        $error("call_panel: DEBOUNCE_CYCLES out of range for DB_W");
    end
    if (REISSUE_CYCLES < 2 || REISSUE_CYCLES > (2 ** RI_W) - 1) begin : g_bad_reissue
        $error("call_panel: REISSUE_CYCLES out of range for RI_W");
    end

    logic [FLOORS-1:0] s1;
    logic [FLOORS-1:0] s2;
    logic [FLOORS-1:0] stb;
    logic [FLOORS-1:0] stb_d;
    logic [RI_W-1:0]   ri_cnt;

    logic [FLOORS-1:0] press_c;
    logic [FLOORS-1:0] at_floor_c;
    logic [FLOORS-1:0] pulse_c;
    logic              idle_c;
    logic              fire_c;

    // Two-flop synchroniser plus previous-cycle copy of the debounced state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            stb_d <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            stb_d <= stb;
        end
    end

`ifdef CALL_PANEL_DEBOUNCE_EN
    logic [FLOORS-1:0][DB_W-1:0] db_cnt;

    // A change on s2 is accepted only after it has persisted DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb    <= '0;
            db_cnt <= '0;
        end else begin
            for (int f = 0; f < int'(FLOORS); f++) begin
                if (s2[f] != stb[f]) begin
                    if (db_cnt[f] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        stb[f]    <= s2[f];
                        db_cnt[f] <= '0;
                    end else begin
                        db_cnt[f] <= db_cnt[f] + DB_W'(1);
                    end
                end else begin
                    db_cnt[f] <= '0;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb <= '0;
        end else begin
            stb <= s2;
        end
    end
`endif

    // Press qualification, served-floor decode and watchdog conditions
    always_comb begin
        at_floor_c = '0;
        for (int unsigned f = 0; f < FLOORS; f++) begin
            at_floor_c[f] = door_open && (floor_pos == POS_W'(f));
        end
        press_c = stb & ~stb_d;
        pulse_c = press_c & ~at_floor_c & ~lamp;
        idle_c  = (|lamp) && !moving_up && !moving_dn && !door_open;
        fire_c  = (ri_cnt == RI_W'(REISSUE_CYCLES - 1));
    end

    // Re-issue word uses the pre-clear lamp state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            floor_req <= '0;
            lamp      <= '0;
            reissue   <= 1'b0;
            ri_cnt    <= '0;
        end else begin
            floor_req <= pulse_c | (fire_c ? lamp : '0);
            lamp      <= (lamp & ~at_floor_c) | pulse_c;
            reissue   <= fire_c;
            if (fire_c || !idle_c) begin
                ri_cnt <= '0;
            end else begin
                ri_cnt <= ri_cnt + RI_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_call_panel.sv
// Randomised scoreboard bench for call_panel; a behavioural model predicts each
// cycle's outputs and a monitor compares them against the DUT.
module tb_call_panel;

    localparam int F = 5;
    localparam int R = 16;
`ifdef CALL_PANEL_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic         clk;
    logic         reset;
    logic [F-1:0] btn;
    logic [2:0]   floor_pos;
    logic         door_open;
    logic         moving_up;
    logic         moving_dn;
    logic [F-1:0] floor_req;
    logic [F-1:0] lamp;
    logic         reissue;

    call_panel #(
        .FLOORS(5), .POS_W(3), .DEBOUNCE_CYCLES(4), .DB_W(4),
        .REISSUE_CYCLES(16), .RI_W(8)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .floor_pos(floor_pos),
        .door_open(door_open), .moving_up(moving_up), .moving_dn(moving_dn),
        .floor_req(floor_req), .lamp(lamp), .reissue(reissue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [F-1:0] req;
        logic [F-1:0] lmp;
        logic         ri;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    // Model state: pipeline samples, accepted level, disagreement run, lamps, idle run
    int m_s1[F];
    int m_s2[F];
    int m_acc[F];
    int m_acc_prev[F];
    int m_run[F];
    int m_lamp[F];
    int m_idle;

    // Reference model: predicts the registered outputs produced at each edge
    always @(posedge clk) begin
        exp_t e;
        int   served;
        int   lit;
        bit   fire;
        bit   newp;
        int   nl[F];
        e = '0;
        if (reset) begin
            for (int f = 0; f < F; f++) begin
                m_s1[f] = 0; m_s2[f] = 0; m_acc[f] = 0; m_acc_prev[f] = 0;
                m_run[f] = 0; m_lamp[f] = 0;
            end
            m_idle = 0;
        end else begin
            served = (door_open && int'(floor_pos) < F) ? int'(floor_pos) : -1;
            fire   = (m_idle == R - 1);
            lit    = 0;
            for (int f = 0; f < F; f++) lit += m_lamp[f];
            for (int f = 0; f < F; f++) begin
                newp     = (m_acc[f] == 1) && (m_acc_prev[f] == 0) && (f != served) && (m_lamp[f] == 0);
                e.req[f] = newp || (fire && m_lamp[f] == 1);
                nl[f]    = ((m_lamp[f] == 1 && f != served) || newp) ? 1 : 0;
            end
            e.ri = fire;
            if (fire) m_idle = 0;
            else if (lit > 0 && !moving_up && !moving_dn && !door_open) m_idle = m_idle + 1;
            else m_idle = 0;
            for (int f = 0; f < F; f++) begin
                m_acc_prev[f] = m_acc[f];
                if (m_s2[f] != m_acc[f]) begin
                    m_run[f] = m_run[f] + 1;
                    if (m_run[f] == D) begin
                        m_acc[f] = m_s2[f];
                        m_run[f] = 0;
                    end
                end else begin
                    m_run[f] = 0;
                end
                m_s2[f]   = m_s1[f];
                m_s1[f]   = int'(btn[f]);
                m_lamp[f] = nl[f];
                e.lmp[f]  = (nl[f] == 1);
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pops the prediction for this edge and compares once outputs settle
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (floor_req !== e.req) begin
                n_fail++;
                $display("FAIL floor_req at %0t: got %b expected %b", $time, floor_req, e.req);
            end
            n_tests++;
            if (lamp !== e.lmp) begin
                n_fail++;
                $display("FAIL lamp at %0t: got %b expected %b", $time, lamp, e.lmp);
            end
            n_tests++;
            if (reissue !== e.ri) begin
                n_fail++;
                $display("FAIL reissue at %0t: got %b expected %b", $time, reissue, e.ri);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic serve(input int f);
        floor_pos = 3'(f);
        door_open = 1'b1;
        cyc(1);
        door_open = 1'b0;
        cyc(2);
    endtask

    initial begin
        int mode;
        n_tests   = 0;
        n_fail    = 0;
        btn       = '0;
        floor_pos = '0;
        door_open = 1'b0;
        moving_up = 1'b0;
        moving_dn = 1'b0;
        reset     = 1'b1;
        cyc(2);
        reset = 1'b0;

        // Held button: single pulse, lamp stays, watchdog re-issues while idle
        btn[3] = 1'b1; cyc(24);
        btn[3] = 1'b0; cyc(10);
        serve(3);

        // Short glitch rejected (when debouncing), longer hold accepted
        btn[2] = 1'b1; cyc(3);
        btn[2] = 1'b0; cyc(8);
        btn[2] = 1'b1; cyc(5);
        btn[2] = 1'b0; cyc(8);
        serve(2);

        // Duplicate press while lit, then served
        btn[4] = 1'b1; cyc(6);
        btn[4] = 1'b0; cyc(4);
        btn[4] = 1'b1; cyc(6);
        btn[4] = 1'b0; cyc(4);
        serve(4);

        // Press absorbed at the open floor
        floor_pos = 3'd1; door_open = 1'b1;
        btn[1] = 1'b1; cyc(8);
        btn[1] = 1'b0; cyc(4);
        door_open = 1'b0; cyc(2);

        // Two lamps lit: re-issue after idle run, movement restarts the run
        btn[0] = 1'b1; btn[4] = 1'b1; cyc(7);
        btn = '0; cyc(36);
        cyc(10); moving_up = 1'b1; cyc(1); moving_up = 1'b0; cyc(12);
        floor_pos = 3'd6; door_open = 1'b1; cyc(1); door_open = 1'b0; cyc(2);
        serve(0);
        serve(4);

        // Reset mid-operation with a button held through it
        btn[1] = 1'b1; btn[2] = 1'b1; cyc(8);
        btn[2] = 1'b0; cyc(3);
        reset = 1'b1;
        #1;
        n_tests++;
        if (lamp !== '0 || floor_req !== '0 || reissue !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: lamp=%b floor_req=%b reissue=%b expected all zero", lamp, floor_req, reissue);
        end
        cyc(1);
        reset = 1'b0;
        cyc(12);
        btn = '0;
        serve(1);

        // Randomised traffic
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int f = 0; f < F; f++) begin
                if ($urandom_range(0, 7) == 0) btn[f] = ~btn[f];
            end
            if ($urandom_range(0, 3) == 0) floor_pos = 3'($urandom_range(0, 7));
            door_open = ($urandom_range(0, 11) == 0);
            if (c % 40 == 0) mode = int'($urandom_range(0, 3));
            moving_up = (mode == 1);
            moving_dn = (mode == 2);
            reset = ($urandom_range(0, 699) == 0);
            cyc(1);
        end
        reset = 1'b0;
        btn = '0;
        door_open = 1'b0;
        moving_up = 1'b0;
        moving_dn = 1'b0;
        cyc(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
